// File: rtl/reg_file.sv
// 32 x 32-bit register file feeding the ALU: two combinational read ports, one write port,
// with $0 hardwired to zero and write-back suppressed (and counted) on signed overflow.
module reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Ra,
  input  logic [ADDR_W-1:0] Rb,
  input  logic [ADDR_W-1:0] Rw,
  input  logic [DATA_W-1:0] busW,
  input  logic              RegWr,
  input  logic              Overflow,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  output logic              OvTrap,
  output logic [CNT_W-1:0]  OvCnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              rw_nonzero;
  logic              commit;
  logic              sup;

  // RegWr gates both terms first so an unknown Overflow during idle cycles cannot leak in
  assign rw_nonzero = (Rw != '0);
  assign commit     = RegWr & ~Overflow & rw_nonzero;
  assign sup        = RegWr &  Overflow & rw_nonzero;

  // No write-to-read bypass: busA/busB feed the ALU, which drives busW
  assign busA = (Ra == '0) ? '0 : regs[Ra];
  assign busB = (Rb == '0) ? '0 : regs[Rb];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[Rw] <= busW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OvTrap <= 1'b0;
      OvCnt  <= '0;
    end else begin
      OvTrap <= sup;
      if (sup && (OvCnt != '1)) begin
        OvCnt <= OvCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed + randomized bench for reg_file, checked against an array-based reference model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  Ra = '0, Rb = '0, Rw = '0;
  logic [31:0] busW = '0;
  logic        RegWr = 1'b0;
  logic        Overflow = 1'b0;
  logic [31:0] busA, busB;
  logic        OvTrap;
  logic [7:0]  OvCnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [32];
  bit          mtrap;
  int          mcnt;
  localparam int CNT_MAX = 255;

  reg_file #(.DATA_W(32), .ADDR_W(5), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .Ra(Ra), .Rb(Rb), .Rw(Rw), .busW(busW),
    .RegWr(RegWr), .Overflow(Overflow), .busA(busA), .busB(busB),
    .OvTrap(OvTrap), .OvCnt(OvCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expect_rd(input int idx);
    return (idx == 0) ? 32'h0 : mdl[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    mtrap = 1'b0;
    mcnt  = 0;
  endtask

  // Apply the architectural rules to whatever inputs are present at the next edge
  task automatic tick();
    bit do_commit, do_sup;
    do_commit = (RegWr === 1'b1) && (Overflow === 1'b0) && (Rw != 0);
    do_sup    = (RegWr === 1'b1) && (Overflow === 1'b1) && (Rw != 0);
    @(posedge clk);
    if (do_commit) mdl[Rw] = busW;
    mtrap = do_sup;
    if (do_sup && mcnt < CNT_MAX) mcnt++;
    #1;
  endtask

  task automatic check_read(input int ra, input int rb, input string tag);
    Ra = ra[4:0];
    Rb = rb[4:0];
    #1;
    chk({tag, "_busA"}, busA, expect_rd(ra));
    chk({tag, "_busB"}, busB, expect_rd(rb));
  endtask

  task automatic check_stat(input string tag);
    chk({tag, "_trap"}, {31'h0, OvTrap}, {31'h0, mtrap});
    chk({tag, "_cnt"}, {24'h0, OvCnt}, mcnt);
  endtask

  task automatic drive_wr(input int rw, input logic [31:0] d, input logic wr, input logic ov);
    Rw = rw[4:0];
    busW = d;
    RegWr = wr;
    Overflow = ov;
  endtask

  initial begin
    model_reset();

    // 1: asynchronous reset between edges
    #2 rst_n = 1'b0;
    model_reset();
    check_read(5, 31, "rst_async");
    check_stat("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 2: write, old value before the edge, new value after
    drive_wr(7, 32'hDEADBEEF, 1'b1, 1'b0);
    check_read(7, 7, "wr7_before");
    tick();
    check_read(7, 6, "wr7_after");
    check_read(8, 7, "wr7_nbr");
    drive_wr(0, 32'h0, 1'b0, 1'b0);

    // 3: writes to $0 are dropped, with and without overflow
    drive_wr(0, 32'hFFFFFFFF, 1'b1, 1'b0);
    tick();
    check_read(0, 0, "r0_plain");
    check_stat("r0_plain");
    drive_wr(0, 32'hFFFFFFFF, 1'b1, 1'b1);
    tick();
    check_read(0, 7, "r0_ovf");
    check_stat("r0_ovf");

    // 4: overflow suppresses the write and pulses the trap once
    drive_wr(3, 32'h12345678, 1'b1, 1'b0);
    tick();
    drive_wr(3, 32'h80000000, 1'b1, 1'b1);
    tick();
    check_read(3, 3, "ovf_sup");
    check_stat("ovf_sup");
    drive_wr(0, 32'h0, 1'b0, 1'b0);
    tick();
    check_stat("ovf_pulse_end");

    // 5: 300 back-to-back suppressed writes saturate the counter
    drive_wr(9, 32'h0BADF00D, 1'b1, 1'b0);
    tick();
    drive_wr(9, 32'hFFFF0000, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) begin
      tick();
      check_stat("sat_run");
    end
    check_read(9, 3, "sat_r9");
    chk("sat_cnt_255", {24'h0, OvCnt}, 32'd255);
    drive_wr(0, 32'h0, 1'b0, 1'b0);
    tick();
    check_stat("sat_idle");

    // 6: reset mid-operation discards the pending write
    #2 rst_n = 1'b0;
    model_reset();
    #2 rst_n = 1'b1;
    @(negedge clk);
    drive_wr(5, 32'h0, 1'b1, 1'b1);
    repeat (3) tick();
    drive_wr(4, 32'hA5A5A5A5, 1'b1, 1'b0);
    tick();
    check_read(4, 9, "pre_rst");
    check_stat("pre_rst");
    drive_wr(4, 32'h1, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_read(4, 7, "mid_rst");
    check_stat("mid_rst");
    @(negedge clk);
    drive_wr(4, 32'h1, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_read(4, 3, "post_rst");
    check_stat("post_rst");

    // Unknown Overflow while idle must not disturb state
    drive_wr(5, 32'hCAFEF00D, 1'b0, 1'bx);
    tick();
    check_read(5, 0, "ov_x_idle");
    check_stat("ov_x_idle");

    // Randomized traffic against the model; pre-edge reads confirm no bypass
    for (int i = 0; i < 400; i++) begin
      drive_wr(int'($urandom_range(0, 31)), $urandom(), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) == 0));
      check_read(int'($urandom_range(0, 31)), int'(Rw), "rand_pre");
      tick();
      check_stat("rand");
    end
    drive_wr(0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) check_read(i, 31 - i, "rand_sweep");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
